// File: rtl/debug_result_encoder.sv
// debug_result_encoder
// Serialises one answered debug command into a framed byte stream for the
// UART transmitter: SYNC_BYTE, code, then size+1 result bytes LSB first.
// Optional build macro DEBUG_CHECKSUM_EN appends an XOR checksum byte
// (code ^ payload bytes) after the payload.
//
// Byte handshake: tx_data/tx_valid are presented by this block; a byte moves
// on every rising clk edge where tx_valid=1 and tx_ready=1. Once tx_valid is
// raised it stays high with tx_data stable until that transfer happens, and
// it only drops mid-frame on reset. tx_ready while tx_valid=0 has no effect.
module debug_result_encoder #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         RESULT_W  = 32   // payload is up to 4 bytes; must be 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          code,
  input  logic [RESULT_W-1:0] result,
  input  logic [1:0]          size,
  output logic                busy,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                done,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_CODE = 3'd2,
    S_DATA = 3'd3,
`ifdef DEBUG_CHECKSUM_EN
    S_CSUM = 3'd4,
`endif
    S_FIN  = 3'd5
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [7:0]            code_q;
  logic [RESULT_W-1:0]   result_q;
  logic [1:0]            size_q;
  logic [1:0]            idx_q;
  logic                  accept;
  logic                  xfer;
  logic [7:0]            data_byte;
`ifdef DEBUG_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  assign accept    = (state_q == S_IDLE) && start;
  assign xfer      = tx_valid && tx_ready;
  assign dbg_state = state_q;

  // Pick the payload byte addressed by the byte index, LSB first.
  always_comb begin
    data_byte = result_q[7:0];
    case (idx_q)
      2'd0: data_byte = result_q[7:0];
      2'd1: data_byte = result_q[15:8];
      2'd2: data_byte = result_q[23:16];
      2'd3: data_byte = result_q[31:24];
      default: data_byte = result_q[7:0];
    endcase
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and Moore outputs; tx_data is 8'h00 whenever nothing is offered.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SYNC;
      end
      S_SYNC: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
        if (xfer) state_d = S_CODE;
      end
      S_CODE: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = code_q;
        if (xfer) state_d = S_DATA;
      end
      S_DATA: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = data_byte;
        if (xfer && (idx_q == size_q)) begin
`ifdef DEBUG_CHECKSUM_EN
          state_d = S_CSUM;
`else
          state_d = S_FIN;
`endif
        end
      end
`ifdef DEBUG_CHECKSUM_EN
      S_CSUM: begin
        busy     = 1'b1;
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (xfer) state_d = S_FIN;
      end
`endif
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the command on acceptance so later input changes cannot
  // disturb the frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q   <= 8'h00;
      result_q <= '0;
      size_q   <= 2'd0;
    end else if (accept) begin
      code_q   <= code;
      result_q <= result;
      size_q   <= size;
    end
  end

  // Byte index: cleared entering DATA, stepped per DATA transfer; exits at
  // idx == size so it never wraps inside a frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= 2'd0;
    end else if (state_q == S_CODE && xfer) begin
      idx_q <= 2'd0;
    end else if (state_q == S_DATA && xfer) begin
      idx_q <= idx_q + 2'd1;
    end
  end

`ifdef DEBUG_CHECKSUM_EN
  // Running XOR over the code byte and every payload byte actually sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= 8'h00;
    end else if (accept) begin
      csum_q <= 8'h00;
    end else if (xfer && (state_q == S_CODE || state_q == S_DATA)) begin
      csum_q <= csum_q ^ tx_data;
    end
  end
`endif

endmodule

// File: tb/tb_debug_result_encoder.sv
// Directed bench for debug_result_encoder with hand-computed frames.
module tb_debug_result_encoder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  code;
  logic [31:0] result;
  logic [1:0]  size;
  logic        busy;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        done;
  logic [2:0]  dbg_state;

  debug_result_encoder dut (
    .clk       (clk),
    .reset     (rst),
    .start     (start),
    .code      (code),
    .result    (result),
    .size      (size),
    .busy      (busy),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  int          xfer_cyc[$];
  logic        bp_mode = 1'b0;
  int          stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // tx_ready driver: tied high, or low for 3 cycles on every offered byte.
  always @(posedge clk) begin
    #1;
    if (!bp_mode) begin
      tx_ready = 1'b1;
      stall_cnt = 0;
    end else if (tx_valid) begin
      if (stall_cnt == 3) begin
        tx_ready = 1'b1;
        stall_cnt = 0;
      end else begin
        tx_ready = 1'b0;
        stall_cnt++;
      end
    end else begin
      tx_ready = 1'b0;
      stall_cnt = 0;
    end
  end

  // Monitor: capture transfers, done pulses, and hold stability during stalls.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, tx_valid}, 32'd1);
        check("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        xfer_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // driver tasks
  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    xfer_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic send(input logic [7:0] c, input logic [31:0] r, input logic [1:0] s);
    @(posedge clk); #1;
    start = 1'b1; code = c; result = r; size = s;
    @(posedge clk); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      if (done) break;
      n++;
    end
    check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    done_cyc = cyc;
  endtask

  task automatic check_frame(input string tag);
    int n;
    check({tag, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
  endtask

  initial begin
    start = 1'b0; code = 8'h00; result = 32'h0; size = 2'd0; tx_ready = 1'b1;
    rst = 1'b1;
    #3;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;

    // Full word, tx_ready tied high.
    clear_sb();
    exp_q = '{8'hA5, 8'h21, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef DEBUG_CHECKSUM_EN
    exp_q.push_back(8'h29);
`endif
    send(8'h21, 32'h12345678, 2'd3);
    check("full_valid_after_start", {31'd0, tx_valid}, 32'd1);
    check("full_first_data", {24'd0, tx_data}, 32'hA5);
    check("full_busy", {31'd0, busy}, 32'd1);
    wait_done("full");
    check("full_fin_busy", {31'd0, busy}, 32'd0);
    check("full_fin_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge clk); #1;
    check_frame("full");
    check("full_done_cnt", done_cnt, 1);
    if (xfer_cyc.size() > 0) begin
      check("full_first_xfer_cyc", xfer_cyc[0], start_cyc);
      check("full_back_to_back", xfer_cyc[xfer_cyc.size()-1] - xfer_cyc[0], exp_q.size() - 1);
      check("full_done_latency", done_cyc, xfer_cyc[xfer_cyc.size()-1] + 1);
    end
    check("full_idle_after", {29'd0, dbg_state}, 32'd0);

    // Single byte.
    clear_sb();
    exp_q = '{8'hA5, 8'h22, 8'hEF};
`ifdef DEBUG_CHECKSUM_EN
    exp_q.push_back(8'hCD);
`endif
    send(8'h22, 32'hDEADBEEF, 2'd0);
    wait_done("single");
    @(posedge clk); #1;
    check_frame("single");
    check("single_done_cnt", done_cnt, 1);

    // Backpressure: 3 stall cycles on each byte.
    clear_sb();
    bp_mode = 1'b1;
    exp_q = '{8'hA5, 8'h21, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef DEBUG_CHECKSUM_EN
    exp_q.push_back(8'h29);
`endif
    send(8'h21, 32'h12345678, 2'd3);
    wait_done("bp");
    @(posedge clk); #1;
    check_frame("bp");
    check("bp_done_cnt", done_cnt, 1);
    bp_mode = 1'b0;
    repeat (2) @(posedge clk);

    // Input stability: change inputs and re-pulse start while busy.
    clear_sb();
    exp_q = '{8'hA5, 8'h33, 8'h44, 8'h33};
`ifdef DEBUG_CHECKSUM_EN
    exp_q.push_back(8'h44);
`endif
    send(8'h33, 32'h11223344, 2'd1);
    start = 1'b1; code = 8'h77; result = 32'hCAFEF00D; size = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("stab");
    repeat (5) @(posedge clk);
    #1;
    check_frame("stab");
    check("stab_done_cnt", done_cnt, 1);
    check("stab_idle", {29'd0, dbg_state}, 32'd0);

    // Reset in the middle of DATA.
    clear_sb();
    send(8'h21, 32'h12345678, 2'd3);
    for (int i = 0; i < 20; i++) begin
      if (dbg_state == 3'd3) break;
      @(posedge clk); #1;
    end
    check("mid_in_data", {29'd0, dbg_state}, 32'd3);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("mid_rst_data", {24'd0, tx_data}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_resume", {31'd0, tx_valid}, 32'd0);
    check("mid_no_done", done_cnt, 0);
    clear_sb();
    exp_q = '{8'hA5, 8'h05, 8'hAA};
`ifdef DEBUG_CHECKSUM_EN
    exp_q.push_back(8'hAF);
`endif
    send(8'h05, 32'h000000AA, 2'd0);
    wait_done("after_rst");
    @(posedge clk); #1;
    check_frame("after_rst");

    // Back-to-back: start in FIN ignored, start in the next IDLE accepted.
    clear_sb();
    exp_q = '{8'hA5, 8'h22, 8'hEF};
`ifdef DEBUG_CHECKSUM_EN
    exp_q.push_back(8'hCD);
`endif
    send(8'h22, 32'hDEADBEEF, 2'd0);
    wait_done("b2b_a");
    start = 1'b1; code = 8'h5A; result = 32'h0000BB66; size = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_fin_start_ignored", {31'd0, tx_valid}, 32'd0);
    check("b2b_idle", {29'd0, dbg_state}, 32'd0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'hBB);
`ifdef DEBUG_CHECKSUM_EN
    exp_q.push_back(8'h87);
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_valid_next", {31'd0, tx_valid}, 32'd1);
    wait_done("b2b_b");
    @(posedge clk); #1;
    check_frame("b2b");
    check("b2b_done_cnt", done_cnt, 2);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
